sub_bytes_seq: RTL and testbench
================================

SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 The parameter shall be: NUM_SBOX, default 4, the number of byte lookups performed per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 The port clk shall be: input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 The port rst shall be: input, 1 bit, reset; synchronous, active-high.
REQ-004 The port in_valid shall be: input, 1 bit, din/inv are valid.
REQ-005 The port in_ready shall be: output, 1 bit, the block can accept a state.
REQ-006 The port din shall be: input, 128 bits, input state; byte k occupies bits [8k+7:8k].
REQ-007 The port inv shall be: input, 1 bit, mode select sampled with din; 0 selects the forward S-box, 1 selects the inverse S-box (FIPS-197).
REQ-008 The port out_valid shall be: output, 1 bit, dout holds a completed result.
REQ-009 The port out_ready shall be: input, 1 bit, the downstream accepts dout.
REQ-010 The port dout shall be: output, 128 bits, substituted state.
REQ-011 The port busy shall be: output, 1 bit, high while in RUN or DONE.

Function
REQ-012 An illegal NUM_SBOX value shall cause an elaboration-time error.
REQ-013 The FSM shall have exactly three states: IDLE, RUN and DONE; the slice counter shall be ceil(log2(16/NUM_SBOX)) bits wide, minimum 1.
REQ-014 In IDLE, in_ready shall be 1; in RUN and DONE, in_ready shall be 0.
REQ-015 The accept event is in_valid & in_ready; on accept, din shall be captured into a 128-bit state register, inv into a mode register, counter cleared, and the FSM moved to RUN.
REQ-016 In RUN, each cycle bytes cnt*NUM_SBOX through cnt*NUM_SBOX+NUM_SBOX-1 of the state register shall be replaced by their S-box image (per the mode register), and all other bytes held.
REQ-017 In RUN, the counter shall increment each cycle; at cnt = 16/NUM_SBOX-1 the FSM shall go to DONE and the counter shall wrap to 0.
REQ-018 Latency: out_valid shall rise exactly 16/NUM_SBOX cycles after the accept edge (16 cycles for NUM_SBOX=1; 1 cycle for NUM_SBOX=16).
REQ-019 In DONE, out_valid shall be 1 and dout shall equal the state register.
REQ-020 In DONE, dout shall be held stable while out_ready=0, with no timeout.
REQ-021 In DONE with out_ready=1, the transfer shall complete and the FSM shall return to IDLE on the next edge; a new accept is possible no earlier than the cycle after that.
REQ-022 When out_valid=0, dout shall be 128'h0.
REQ-023 in_valid, din and inv shall be ignored outside IDLE.
REQ-024 Changes to inv after accept shall not affect the result in flight.
REQ-025 S-box tables shall be combinational lookups inside the block: NUM_SBOX forward plus NUM_SBOX inverse, or a shared equivalent; no external sbox instance.
REQ-026 The output shall be identical for every legal NUM_SBOX given the same din/inv; only latency differs.

Reset
REQ-027 While rst=1 at a clock edge, the FSM shall go to IDLE, counter shall be 0, the state register shall be 0, and the mode register shall be 0.
REQ-028 During the reset cycle out_valid, busy and in_ready shall be 0; in_ready shall be 1 in the first cycle after rst deasserts.
REQ-029 Reset asserted in RUN or DONE shall abort the operation, discard the partial result, and produce no out_valid pulse.
REQ-030 Reset shall take priority over accept and over output transfer in the same cycle.

Verification
REQ-031 The bench shall cover: NUM_SBOX=4, din=00112233445566778899aabbccddeeff, inv=0 -> out_valid 4 cycles after accept, dout=638293c31bfc33f5c4eeacea4bc12816.
REQ-032 The bench shall cover: same din with NUM_SBOX=1, 2, 8, 16 -> identical dout; out_valid after 16, 8, 2 and 1 cycles respectively.
REQ-033 The bench shall cover: din=638293c31bfc33f5c4eeacea4bc12816, inv=1 -> dout=00112233445566778899aabbccddeeff; din all 8'h53 with inv=0 -> all 8'hED.
REQ-034 The bench shall cover: result ready with out_ready=0 for 10 cycles -> out_valid and dout stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 The bench shall cover: rst=1 on the second RUN cycle -> next cycle out_valid=0, busy=0, dout=0, in_ready=1 after release, and no stale result emitted.
REQ-036 The bench shall cover: inv toggled and din changed every cycle during RUN -> result matches the values sampled at accept only.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: AES SubBytes / InvSubBytes over a 128-bit state, computed
// NUM_SBOX bytes per cycle. Byte k of the state is bits [8k+7:8k].
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   din/inv valid
//   in_ready   block idle and able to take a state
//   din        128-bit input state
//   inv        0 = forward S-box, 1 = inverse S-box (sampled with din)
//   out_valid  dout holds a completed result
//   out_ready  downstream accepts dout
//   dout       substituted state, zero when out_valid is low
//   busy       operation in progress or result waiting

// One S-box lane. Forward and inverse share a single GF(2^8) inverter:
//   fwd: y = affine(inv(a))      inv: y = inv(affine^-1(a))
module sub_bytes_seq_lane (
  input  logic       inv_i,
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r;
  endfunction

  logic [7:0] pre, g;

  always_comb begin
    pre = inv_i ? (rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05) : a_i;
    g   = ginv(pre);
    y_o = inv_i ? g : (g ^ rotl(g, 1) ^ rotl(g, 2) ^ rotl(g, 3) ^ rotl(g, 4) ^ 8'h63);
  end
endmodule

module sub_bytes_seq #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] din,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);
  localparam int SLICES = 16 / NUM_SBOX;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int SH     = $clog2(NUM_SBOX);
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("sub_bytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   state_q, state_d;
  logic           mode_q, mode_d;
  logic           accept;

  logic [3:0]                     base;
  logic [NUM_SBOX-1:0][3:0]       idx;
  logic [NUM_SBOX-1:0][7:0]       lane_a, lane_y;

  assign accept = in_valid & in_ready;

  // First byte of the current slice; for NUM_SBOX=16 the shift drops cnt out.
  assign base = 4'(4'(cnt_q) << SH);

  for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
    assign idx[l]    = base + 4'(l);
    assign lane_a[l] = state_q[{idx[l], 3'b000} +: 8];
    sub_bytes_seq_lane u_lane (
      .inv_i (mode_q),
      .a_i   (lane_a[l]),
      .y_o   (lane_y[l])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Next-state logic
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (accept)        st_d = RUN;
      RUN:     if (cnt_q == LAST) st_d = DONE;
      DONE:    if (out_ready)     st_d = IDLE;
      default:                    st_d = IDLE;
    endcase
  end

  // Outputs; rst masks the handshake/status outputs during the reset cycle.
  always_comb begin
    in_ready  = (st_q == IDLE) & ~rst;
    out_valid = (st_q == DONE) & ~rst;
    busy      = ((st_q == RUN) | (st_q == DONE)) & ~rst;
    dout      = out_valid ? state_q : 128'h0;
  end

  // Datapath
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = din;
      mode_d  = inv;
      cnt_d   = '0;
    end else if (st_q == RUN) begin
      for (int l = 0; l < NUM_SBOX; l++)
        state_d[{idx[l], 3'b000} +: 8] = lane_y[l];
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: five instances (NUM_SBOX = 1, 2, 4, 8, 16) share
// one set of inputs; index g holds NUM_SBOX = 1 << g. Expected values are
// FIPS-197 S-box results worked by hand.
module tb_sub_bytes_seq;
  localparam logic [127:0] V0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1   = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] V53  = {16{8'h53}};
  localparam logic [127:0] VED  = {16{8'hed}};

  logic         clk = 1'b0;
  logic         rst, in_valid, inv, out_ready;
  logic [127:0] din;
  logic [4:0]   ov, ir, bz;
  logic [127:0] dq [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_seq #(.NUM_SBOX(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .din       (din),
      .inv       (inv),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .dout      (dq[g]),
      .busy      (bz[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one state on all instances, then watch 20 cycles with out_ready=0.
  // With scramble set, din/inv/in_valid churn every cycle after the accept.
  task automatic run_all(input logic [127:0] d, input logic m, input bit scramble,
                         input logic [127:0] exp);
    int lat [5];
    din = d; inv = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int g = 0; g < 5; g++) lat[g] = 0;
    for (int k = 1; k <= 20; k++) begin
      if (scramble) begin
        din = {$urandom, $urandom, $urandom, $urandom};
        inv = ~inv;
        in_valid = 1'b1;
      end
      tick();
      for (int g = 0; g < 5; g++)
        if (ov[g] && lat[g] == 0) lat[g] = k;
    end
    in_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("lat_n%0d", 1 << g), 128'(lat[g]), 128'(16 >> g));
      chk($sformatf("dout_n%0d", 1 << g), dq[g], exp);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_ov", 128'(ov), 128'h0);
    chk("rel_ir", 128'(ir), 128'h1f);
    chk("rel_dout", dq[2], 128'h0);
  endtask

  initial begin
    int hits;
    rst = 1'b1; in_valid = 1'b0; inv = 1'b0; out_ready = 1'b0; din = '0;
    tick();
    tick();
    chk("rst_ov", 128'(ov), 128'h0);
    chk("rst_busy", 128'(bz), 128'h0);
    chk("rst_ir", 128'(ir), 128'h0);
    chk("rst_dout", dq[2], 128'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ir", 128'(ir), 128'h1f);

    // Forward vector on all widths
    run_all(V0, 1'b0, 1'b0, V1);
    chk("done_busy", 128'(bz), 128'h1f);
    release_out();

    // Inverse vector
    run_all(V1, 1'b1, 1'b0, V0);
    release_out();

    // Uniform 0x53 -> 0xED
    run_all(V53, 1'b0, 1'b0, VED);

    // Stall in DONE with in_valid pulses ignored
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      din = ~V53;
      tick();
      chk("stall_ov", 128'(ov[2]), 128'h1);
      chk("stall_dout", dq[2], VED);
      chk("stall_ir", 128'(ir[2]), 128'h0);
    end
    in_valid = 1'b0;
    release_out();

    // Reset on the second RUN cycle aborts without a result
    din = V0; inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_busy", 128'(bz[2]), 128'h1);
    rst = 1'b1;
    tick();
    chk("abort_ov", 128'(ov), 128'h0);
    chk("abort_busy", 128'(bz), 128'h0);
    chk("abort_dout", dq[2], 128'h0);
    rst = 1'b0;
    #1;
    chk("abort_ir", 128'(ir), 128'h1f);
    hits = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ov != 5'h0) hits++;
    end
    chk("abort_no_ov", 128'(hits), 128'h0);

    // Inputs churning during RUN must not affect the result
    run_all(V0, 1'b0, 1'b1, V1);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
